// File: rtl/axis_master.sv
// AXI4-Stream master: buffers user bytes in a first-word-fall-through FIFO and
// releases them as frames once a whole packet (or a full FIFO) is waiting.
module axis_master #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     m_axis_aclk,
  input  logic                     m_axis_arst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         pkt_sent
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // Each entry holds {last, data}; storage is data path and is never reset.
  logic [DATA_W:0]  mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    avail_q, avail_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  state_t           state_q, state_d;

  logic              full, empty;
  logic              push, pop, push_last, pop_last;
  logic [DATA_W:0]   head;
  logic              head_last;
  logic [DATA_W-1:0] head_data;
  logic              tvalid;

  assign full      = (count_q == FULL);
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[DATA_W];
  assign head_data = head[DATA_W-1:0];

  assign push      = in_valid && !full;
  assign push_last = push && in_last;
  assign tvalid    = (state_q == SEND) && !empty;
  assign pop       = tvalid && m_axis_tready;
  assign pop_last  = pop && head_last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    avail_d  = avail_q;
    sent_d   = sent_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // pkt_avail counts complete packets sitting in the FIFO
    case ({push_last, pop_last})
      2'b10:   avail_d = avail_q + 1'b1;
      2'b01:   avail_d = avail_q - 1'b1;
      default: avail_d = avail_q;
    endcase
    if (pop_last) sent_d = sent_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if ((avail_q != '0) || full) state_d = SEND;
      SEND: if (pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= '0;
      sent_q   <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
      sent_q   <= sent_d;
      state_q  <= state_d;
    end
  end

  assign in_ready      = !full;
  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = tvalid ? head_data : '0;
  assign m_axis_tlast  = tvalid ? head_last : 1'b0;
  assign fifo_count    = count_q;
  assign pkt_sent      = sent_q;

endmodule

// File: tb/tb_axis_master.sv
// Directed bench for axis_master: reset, framing, backpressure, full FIFO,
// simultaneous push/pop, back-to-back packets and mid-frame reset.
module tb_axis_master;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, in_last, in_ready;
  logic [DATA_W-1:0] tdata;
  logic              tvalid, tlast, tready;
  logic [4:0]        fifo_count;
  logic [CNT_W-1:0]  pkt_sent;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .m_axis_aclk(clk), .m_axis_arst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tready(tready), .fifo_count(fifo_count), .pkt_sent(pkt_sent)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_tvalid(input string tag);
    int k;
    k = 0;
    while (!tvalid && k < 10) begin tick(); k++; end
    n_cmp++;
    if (tvalid !== 1'b1) begin n_err++; $display("FAIL %s_wait: tvalid=%0b required 1", tag, tvalid); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; tready = 1'b0;
    tick(); tick();
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %0b want 0", tvalid); end
    n_cmp++; if (tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %0b want 0", tlast); end
    n_cmp++; if (tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata: got %h want 00", tdata); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_cmp++; if (pkt_sent !== 16'd0) begin n_err++; $display("FAIL rst_sent: got %0d want 0", pkt_sent); end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_count_rel: got %0d want 0", fifo_count); end
  endtask

  task automatic test_basic();
    tready = 1'b1;
    push_byte(8'hA0, 1'b0); push_byte(8'hA1, 1'b0); push_byte(8'hA2, 1'b0);
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL basic_nolast: tvalid=%0b want 0", tvalid); end
    push_byte(8'hA3, 1'b1);
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL basic_lat1: tvalid=%0b want 0", tvalid); end
    tick();
    n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL basic_lat2: tvalid=%0b want 1", tvalid); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL basic_v%0d: got %0b want 1", i, tvalid); end
      n_cmp++; if (tdata !== 8'(8'hA0 + i)) begin n_err++; $display("FAIL basic_d%0d: got %h want %h", i, tdata, 8'(8'hA0 + i)); end
      n_cmp++; if (tlast !== (i == 3)) begin n_err++; $display("FAIL basic_l%0d: got %0b want %0b", i, tlast, (i == 3)); end
      tick();
    end
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL basic_end_v: got %0b want 0", tvalid); end
    n_cmp++; if (pkt_sent !== 16'd1) begin n_err++; $display("FAIL basic_sent: got %0d want 1", pkt_sent); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL basic_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_backpressure();
    int idx;
    bit stall;
    logic [7:0] pd;
    logic pl;
    tready = 1'b0;
    push_byte(8'hA0, 1'b0); push_byte(8'hA1, 1'b0); push_byte(8'hA2, 1'b0); push_byte(8'hA3, 1'b1);
    wait_tvalid("bp");
    idx = 0; stall = 1'b0; pd = '0; pl = 1'b0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      tready = (k % 2 == 0);
      if (stall) begin
        n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL bp_hold_v: got %0b want 1", tvalid); end
        n_cmp++; if (tdata !== pd) begin n_err++; $display("FAIL bp_hold_d: got %h want %h", tdata, pd); end
        n_cmp++; if (tlast !== pl) begin n_err++; $display("FAIL bp_hold_l: got %0b want %0b", tlast, pl); end
      end
      if (tvalid && tready) begin
        n_cmp++; if (tdata !== 8'(8'hA0 + idx)) begin n_err++; $display("FAIL bp_d%0d: got %h want %h", idx, tdata, 8'(8'hA0 + idx)); end
        n_cmp++; if (tlast !== (idx == 3)) begin n_err++; $display("FAIL bp_l%0d: got %0b want %0b", idx, tlast, (idx == 3)); end
        idx++;
      end
      stall = tvalid && !tready; pd = tdata; pl = tlast;
      tick();
    end
    n_cmp++; if (idx != 4) begin n_err++; $display("FAIL bp_beats: got %0d want 4", idx); end
    tready = 1'b1;
    tick(); tick();
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL bp_dup: tvalid=%0b want 0", tvalid); end
    n_cmp++; if (pkt_sent !== 16'd2) begin n_err++; $display("FAIL bp_sent: got %0d want 2", pkt_sent); end
  endtask

  task automatic test_full();
    tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
      n_cmp++; if (in_ready !== (i < 16)) begin n_err++; $display("FAIL full_rdy%0d: got %0b want %0b", i, in_ready, (i < 16)); end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", fifo_count); end
    n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL full_send: tvalid=%0b want 1", tvalid); end
    tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'(j)) begin n_err++; $display("FAIL full_drain%0d: v=%0b d=%h want v=1 d=%h", j, tvalid, tdata, 8'(j)); end
      tick();
    end
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL full_empty_v: got %0b want 0", tvalid); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL full_empty_cnt: got %0d want 0", fifo_count); end
    tick();
    push_byte(8'h55, 1'b1);
    n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'h55 || tlast !== 1'b1) begin n_err++; $display("FAIL full_tail: v=%0b d=%h l=%0b want 1/55/1", tvalid, tdata, tlast); end
    tick();
    n_cmp++; if (pkt_sent !== 16'd3) begin n_err++; $display("FAIL full_sent: got %0d want 3", pkt_sent); end
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL full_done_v: got %0b want 0", tvalid); end
  endtask

  task automatic test_simultaneous();
    tready = 1'b0;
    push_byte(8'hC0, 1'b1);
    wait_tvalid("sim");
    n_cmp++; if (tdata !== 8'hC0) begin n_err++; $display("FAIL sim_head: got %h want c0", tdata); end
    tready = 1'b1; in_valid = 1'b1; in_data = 8'hD0; in_last = 1'b1;
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL sim_pre_cnt: got %0d want 1", fifo_count); end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL sim_cnt: got %0d want 1", fifo_count); end
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL sim_idle: tvalid=%0b want 0", tvalid); end
    n_cmp++; if (pkt_sent !== 16'd4) begin n_err++; $display("FAIL sim_sent1: got %0d want 4", pkt_sent); end
    tick();
    n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'hD0 || tlast !== 1'b1) begin n_err++; $display("FAIL sim_d0: v=%0b d=%h l=%0b want 1/d0/1", tvalid, tdata, tlast); end
    tick();
    n_cmp++; if (pkt_sent !== 16'd5) begin n_err++; $display("FAIL sim_sent2: got %0d want 5", pkt_sent); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL sim_cnt_end: got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ed [7] = '{8'hE0, 8'hE1, 8'hE2, 8'h00, 8'hF0, 8'hF1, 8'hF2};
    logic       el [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tready = 1'b0;
    push_byte(8'hE0, 1'b0); push_byte(8'hE1, 1'b0); push_byte(8'hE2, 1'b1);
    push_byte(8'hF0, 1'b0); push_byte(8'hF1, 1'b0); push_byte(8'hF2, 1'b1);
    tready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (tvalid !== ev[c] || tdata !== ed[c] || tlast !== el[c]) begin
        n_err++;
        $display("FAIL b2b_c%0d: v=%0b d=%h l=%0b want v=%0b d=%h l=%0b", c, tvalid, tdata, tlast, ev[c], ed[c], el[c]);
      end
      tick();
    end
    n_cmp++; if (pkt_sent !== 16'd7) begin n_err++; $display("FAIL b2b_sent: got %0d want 7", pkt_sent); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL b2b_cnt: got %0d want 0", fifo_count); end
  endtask

  task automatic test_mid_reset();
    tready = 1'b1;
    push_byte(8'h60, 1'b0); push_byte(8'h61, 1'b0); push_byte(8'h62, 1'b0); push_byte(8'h63, 1'b1);
    tick();
    n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'h60) begin n_err++; $display("FAIL mr_b0: v=%0b d=%h want 1/60", tvalid, tdata); end
    tick();
    n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'h61) begin n_err++; $display("FAIL mr_b1: v=%0b d=%h want 1/61", tvalid, tdata); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00) begin n_err++; $display("FAIL mr_out: v=%0b l=%0b d=%h want 0/0/00", tvalid, tlast, tdata); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL mr_cnt: got %0d want 0", fifo_count); end
    n_cmp++; if (pkt_sent !== 16'd0) begin n_err++; $display("FAIL mr_sent: got %0d want 0", pkt_sent); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (tvalid !== 1'b0 || fifo_count !== 5'd0) begin n_err++; $display("FAIL mr_stale%0d: v=%0b cnt=%0d want 0/0", k, tvalid, fifo_count); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_in_ready: got %0b want 1", in_ready); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_full();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
